// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: op codes, stack limits,
// and small decode helpers used by the stage and its stack pointer unit.
package mem_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_ALU   = 3'd1,
        OP_LOAD  = 3'd2,
        OP_STORE = 3'd3,
        OP_PUSH  = 3'd4,
        OP_POP   = 3'd5,
        OP_CALL  = 3'd6,
        OP_RET   = 3'd7
    } op_e;

    localparam logic [7:0] STACK_TOP_DEF    = 8'hFF;
    localparam logic [7:0] STACK_BOTTOM_DEF = 8'hC0;

    // Ops that write to the stack and move SP down.
    function automatic logic is_push(input op_e op);
        return (op == OP_PUSH) || (op == OP_CALL);
    endfunction

    // Ops that read from the stack and move SP up.
    function automatic logic is_pop(input op_e op);
        return (op == OP_POP) || (op == OP_RET);
    endfunction

endpackage

// File: rtl/stack_ptr_unit.sv
// Full-descending stack pointer with overflow/underflow detection and a
// sticky error flag. Faulting operations leave SP unchanged.
module stack_ptr_unit
    import mem_pkg::*;
#(
    parameter logic [7:0] STACK_TOP    = STACK_TOP_DEF,
    parameter logic [7:0] STACK_BOTTOM = STACK_BOTTOM_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       push,
    input  logic       pop,
    output logic [7:0] sp,
    output logic [7:0] push_addr,
    output logic [7:0] pop_addr,
    output logic       ovf,
    output logic       udf,
    output logic       stk_err
);

    logic [7:0] sp_q, sp_d;
    logic       stk_err_q, stk_err_d;

    // Fault detection, addresses and next SP / error state.
    always_comb begin
        push_addr = sp_q;
        pop_addr  = sp_q + 8'd1;
        ovf       = en && push && (sp_q < STACK_BOTTOM);
        udf       = en && pop && (sp_q == STACK_TOP);
        sp_d      = sp_q;
        stk_err_d = stk_err_q | ovf | udf;
        if (en && push && !ovf) begin
            sp_d = sp_q - 8'd1;
        end else if (en && pop && !udf) begin
            sp_d = sp_q + 8'd1;
        end
    end

    // SP and sticky error register; only reset clears the error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sp_q      <= STACK_TOP;
            stk_err_q <= 1'b0;
        end else begin
            sp_q      <= sp_d;
            stk_err_q <= stk_err_d;
        end
    end

    assign sp      = sp_q;
    assign stk_err = stk_err_q;

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-access pipeline stage: drives the DataMEM controls from the EX/MEM
// operation, owns the stack pointer and the MEM/WB register, and merges the
// registered memory read data into write-back and the RET redirect.
module mem_stage_ctrl
    import mem_pkg::*;
#(
    parameter logic [7:0] STACK_TOP    = STACK_TOP_DEF,
    parameter logic [7:0] STACK_BOTTOM = STACK_BOTTOM_DEF
) (
    input  logic       Clk,
    input  logic       rst_n,
    input  logic       stall,
    input  logic       flush,
    input  logic       ex_valid,
    input  logic [2:0] ex_op,
    input  logic [7:0] ex_addr,
    input  logic [7:0] ex_wdata,
    input  logic [7:0] ex_alu,
    input  logic [1:0] ex_rd,
    input  logic       ex_reg_we,
    output logic       mem_we,
    output logic       mem_re,
    output logic [7:0] mem_a,
    output logic [7:0] mem_wd,
    input  logic [7:0] mem_rd,
    output logic       wb_valid,
    output logic       wb_we,
    output logic [1:0] wb_rd,
    output logic [7:0] wb_data,
    output logic       ret_valid,
    output logic [7:0] ret_pc,
    output logic [7:0] sp,
    output logic       stk_err
);

    op_e        op;
    logic       act;
    logic       push_req, pop_req;
    logic [7:0] push_addr, pop_addr;
    logic       ovf, udf;

    logic       wb_valid_q, wb_valid_d;
    logic       wb_we_q, wb_we_d;
    logic [1:0] wb_rd_q, wb_rd_d;
    logic       wb_load_q, wb_load_d;
    logic       wb_zero_q, wb_zero_d;
    logic [7:0] wb_alu_q, wb_alu_d;
    logic       ret_valid_q, ret_valid_d;

    // Decode and access qualifier; flush and stall both block side effects.
    always_comb begin
        op       = op_e'(ex_op);
        act      = ex_valid && !stall && !flush && rst_n;
        push_req = is_push(op);
        pop_req  = is_pop(op);
    end

    stack_ptr_unit #(
        .STACK_TOP    (STACK_TOP),
        .STACK_BOTTOM (STACK_BOTTOM)
    ) u_sp (
        .clk       (Clk),
        .rst_n     (rst_n),
        .en        (act),
        .push      (push_req),
        .pop       (pop_req),
        .sp        (sp),
        .push_addr (push_addr),
        .pop_addr  (pop_addr),
        .ovf       (ovf),
        .udf       (udf),
        .stk_err   (stk_err)
    );

    // DataMEM drive; faulting stack ops keep the address but drop WE/RE.
    always_comb begin
        mem_we = 1'b0;
        mem_re = 1'b0;
        mem_a  = '0;
        mem_wd = '0;
        if (act) begin
            unique case (op)
                OP_LOAD: begin
                    mem_re = 1'b1;
                    mem_a  = ex_addr;
                end
                OP_STORE: begin
                    mem_we = 1'b1;
                    mem_a  = ex_addr;
                    mem_wd = ex_wdata;
                end
                OP_PUSH, OP_CALL: begin
                    mem_we = !ovf;
                    mem_a  = push_addr;
                    mem_wd = ex_wdata;
                end
                OP_POP, OP_RET: begin
                    mem_re = !udf;
                    mem_a  = pop_addr;
                end
                default: ;
            endcase
        end
    end

    // MEM/WB next state: hold on stall, otherwise capture the EX/MEM op.
    always_comb begin
        wb_valid_d  = wb_valid_q;
        wb_we_d     = wb_we_q;
        wb_rd_d     = wb_rd_q;
        wb_load_d   = wb_load_q;
        wb_zero_d   = wb_zero_q;
        wb_alu_d    = wb_alu_q;
        ret_valid_d = 1'b0;
        if (!stall) begin
            wb_valid_d  = ex_valid && !flush;
            wb_we_d     = ex_reg_we && wb_valid_d && (op != OP_RET);
            wb_rd_d     = ex_rd;
            wb_load_d   = act && ((op == OP_LOAD) || ((op == OP_POP) && !udf));
            wb_zero_d   = act && (op == OP_POP) && udf;
            wb_alu_d    = ex_alu;
            ret_valid_d = act && (op == OP_RET) && !udf;
        end
    end

    // MEM/WB register; reset discards any in-flight load.
    always_ff @(posedge Clk) begin
        if (!rst_n) begin
            wb_valid_q  <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_rd_q     <= '0;
            wb_load_q   <= 1'b0;
            wb_zero_q   <= 1'b0;
            wb_alu_q    <= '0;
            ret_valid_q <= 1'b0;
        end else begin
            wb_valid_q  <= wb_valid_d;
            wb_we_q     <= wb_we_d;
            wb_rd_q     <= wb_rd_d;
            wb_load_q   <= wb_load_d;
            wb_zero_q   <= wb_zero_d;
            wb_alu_q    <= wb_alu_d;
            ret_valid_q <= ret_valid_d;
        end
    end

    // Write-back merge of registered memory data and the RET target.
    always_comb begin
        if (wb_load_q) begin
            wb_data = mem_rd;
        end else if (wb_zero_q) begin
            wb_data = 8'h00;
        end else begin
            wb_data = wb_alu_q;
        end
        ret_pc = mem_rd;
    end

    assign wb_valid  = wb_valid_q;
    assign wb_we     = wb_we_q;
    assign wb_rd     = wb_rd_q;
    assign ret_valid = ret_valid_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl with a 256x8 registered-read DataMEM model.
module tb_mem_stage_ctrl;
    import mem_pkg::*;

    logic       Clk;
    logic       rst_n;
    logic       stall;
    logic       flush;
    logic       ex_valid;
    logic [2:0] ex_op;
    logic [7:0] ex_addr;
    logic [7:0] ex_wdata;
    logic [7:0] ex_alu;
    logic [1:0] ex_rd;
    logic       ex_reg_we;
    logic       mem_we;
    logic       mem_re;
    logic [7:0] mem_a;
    logic [7:0] mem_wd;
    logic [7:0] mem_rd;
    logic       wb_valid;
    logic       wb_we;
    logic [1:0] wb_rd;
    logic [7:0] wb_data;
    logic       ret_valid;
    logic [7:0] ret_pc;
    logic [7:0] sp;
    logic       stk_err;

    logic [7:0] dmem [256];

    int unsigned n_checks;
    int unsigned n_pass;

    mem_stage_ctrl #(
        .STACK_TOP    (8'hFF),
        .STACK_BOTTOM (8'hC0)
    ) dut (
        .Clk       (Clk),
        .rst_n     (rst_n),
        .stall     (stall),
        .flush     (flush),
        .ex_valid  (ex_valid),
        .ex_op     (ex_op),
        .ex_addr   (ex_addr),
        .ex_wdata  (ex_wdata),
        .ex_alu    (ex_alu),
        .ex_rd     (ex_rd),
        .ex_reg_we (ex_reg_we),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_a     (mem_a),
        .mem_wd    (mem_wd),
        .mem_rd    (mem_rd),
        .wb_valid  (wb_valid),
        .wb_we     (wb_we),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .ret_valid (ret_valid),
        .ret_pc    (ret_pc),
        .sp        (sp),
        .stk_err   (stk_err)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // DataMEM model: synchronous write, registered read.
    always @(posedge Clk) begin
        if (mem_we) dmem[mem_a] <= mem_wd;
        if (mem_re) mem_rd <= dmem[mem_a];
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic [2:0] op, input logic [7:0] addr, input logic [7:0] wdata,
                          input logic [7:0] alu, input logic [1:0] rd, input logic we);
        ex_valid  = 1'b1;
        ex_op     = op;
        ex_addr   = addr;
        ex_wdata  = wdata;
        ex_alu    = alu;
        ex_rd     = rd;
        ex_reg_we = we;
        #1;
    endtask

    task automatic idle();
        ex_valid  = 1'b0;
        ex_op     = OP_NOP;
        ex_reg_we = 1'b0;
        #1;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        mem_rd    = 8'h00;
        for (int i = 0; i < 256; i++) dmem[i] = 8'h00;
        rst_n     = 1'b0;
        stall     = 1'b0;
        flush     = 1'b0;
        ex_valid  = 1'b0;
        ex_op     = OP_NOP;
        ex_addr   = 8'h00;
        ex_wdata  = 8'h00;
        ex_alu    = 8'h00;
        ex_rd     = 2'd0;
        ex_reg_we = 1'b0;

        // Reset with a LOAD presented: no access allowed.
        set_op(OP_LOAD, 8'h10, 8'h00, 8'h00, 2'd1, 1'b1);
        check("rst_re", 8'(mem_re), 8'h00);
        tick();
        tick();
        rst_n = 1'b1;
        idle();
        check("rst_sp", sp, 8'hFF);
        check("rst_err", 8'(stk_err), 8'h00);
        check("rst_wbv", 8'(wb_valid), 8'h00);
        check("rst_ret", 8'(ret_valid), 8'h00);

        // STORE then LOAD with one-cycle latency.
        set_op(OP_STORE, 8'h10, 8'hA5, 8'h00, 2'd0, 1'b0);
        check("st_we", 8'(mem_we), 8'h01);
        check("st_a", mem_a, 8'h10);
        check("st_wd", mem_wd, 8'hA5);
        tick();
        set_op(OP_LOAD, 8'h10, 8'h00, 8'h00, 2'd2, 1'b1);
        check("ld_re", 8'(mem_re), 8'h01);
        check("ld_a", mem_a, 8'h10);
        tick();
        idle();
        check("ld_wbv", 8'(wb_valid), 8'h01);
        check("ld_wbwe", 8'(wb_we), 8'h01);
        check("ld_wbrd", 8'(wb_rd), 8'h02);
        check("ld_data", wb_data, 8'hA5);

        // ALU pass-through.
        set_op(OP_ALU, 8'h00, 8'h00, 8'h5A, 2'd1, 1'b1);
        check("alu_noacc", 8'({mem_we, mem_re}), 8'h00);
        tick();
        idle();
        check("alu_data", wb_data, 8'h5A);
        check("alu_rd", 8'(wb_rd), 8'h01);

        // PUSH, PUSH, POP, POP.
        set_op(OP_PUSH, 8'h00, 8'h11, 8'h00, 2'd0, 1'b0);
        check("p1_we", 8'(mem_we), 8'h01);
        check("p1_a", mem_a, 8'hFF);
        check("p1_wd", mem_wd, 8'h11);
        tick();
        check("p1_sp", sp, 8'hFE);
        set_op(OP_PUSH, 8'h00, 8'h22, 8'h00, 2'd0, 1'b0);
        check("p2_a", mem_a, 8'hFE);
        tick();
        check("p2_sp", sp, 8'hFD);
        set_op(OP_POP, 8'h00, 8'h00, 8'h00, 2'd1, 1'b1);
        check("q1_re", 8'(mem_re), 8'h01);
        check("q1_a", mem_a, 8'hFE);
        tick();
        check("q1_sp", sp, 8'hFE);
        check("q1_data", wb_data, 8'h22);
        set_op(OP_POP, 8'h00, 8'h00, 8'h00, 2'd1, 1'b1);
        check("q2_a", mem_a, 8'hFF);
        tick();
        idle();
        check("q2_sp", sp, 8'hFF);
        check("q2_data", wb_data, 8'h11);

        // CALL then RET.
        set_op(OP_CALL, 8'h00, 8'h40, 8'h00, 2'd0, 1'b0);
        check("call_we", 8'(mem_we), 8'h01);
        check("call_a", mem_a, 8'hFF);
        tick();
        check("call_sp", sp, 8'hFE);
        set_op(OP_RET, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0);
        check("ret_re", 8'(mem_re), 8'h01);
        check("ret_a", mem_a, 8'hFF);
        tick();
        idle();
        check("ret_v", 8'(ret_valid), 8'h01);
        check("ret_pc", ret_pc, 8'h40);
        check("ret_sp", sp, 8'hFF);
        check("ret_wbwe", 8'(wb_we), 8'h00);
        check("ret_mem", dmem[8'hFF], 8'h40);
        tick();
        check("ret_pulse", 8'(ret_valid), 8'h00);

        // Underflow POP at reset SP.
        set_op(OP_POP, 8'h00, 8'h00, 8'h77, 2'd3, 1'b1);
        check("udf_re", 8'(mem_re), 8'h00);
        tick();
        idle();
        check("udf_data", wb_data, 8'h00);
        check("udf_err", 8'(stk_err), 8'h01);
        check("udf_sp", sp, 8'hFF);
        check("udf_wbv", 8'(wb_valid), 8'h01);

        // Fill the stack down to STACK_BOTTOM, then overflow.
        for (int i = 0; i < 64; i++) begin
            set_op(OP_PUSH, 8'h00, 8'(i), 8'h00, 2'd0, 1'b0);
            check("fill_a", mem_a, 8'(8'hFF - i));
            tick();
        end
        check("fill_sp", sp, 8'hBF);
        set_op(OP_PUSH, 8'h00, 8'hEE, 8'h00, 2'd0, 1'b0);
        check("ovf_we", 8'(mem_we), 8'h00);
        tick();
        idle();
        check("ovf_sp", sp, 8'hBF);
        check("ovf_err", 8'(stk_err), 8'h01);
        check("ovf_wbv", 8'(wb_valid), 8'h01);

        // Flushed STORE leaves no trace.
        flush = 1'b1;
        set_op(OP_STORE, 8'h20, 8'h99, 8'h00, 2'd0, 1'b0);
        check("fl_we", 8'(mem_we), 8'h00);
        tick();
        flush = 1'b0;
        idle();
        check("fl_wbv", 8'(wb_valid), 8'h00);
        check("fl_mem", dmem[8'h20], 8'h00);

        // LOAD then three stalled cycles: write-back holds.
        set_op(OP_LOAD, 8'h10, 8'h00, 8'h00, 2'd3, 1'b1);
        tick();
        check("sl_data", wb_data, 8'hA5);
        stall = 1'b1;
        set_op(OP_PUSH, 8'h20, 8'h33, 8'h00, 2'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("sl_noacc", 8'({mem_we, mem_re}), 8'h00);
            tick();
            check("sl_hold", wb_data, 8'hA5);
            check("sl_rd", 8'(wb_rd), 8'h03);
            check("sl_sp", sp, 8'hBF);
        end
        stall = 1'b0;
        idle();

        // Reset asserted during a LOAD.
        rst_n = 1'b0;
        set_op(OP_LOAD, 8'h10, 8'h00, 8'h00, 2'd2, 1'b1);
        check("rl_re", 8'(mem_re), 8'h00);
        tick();
        rst_n = 1'b1;
        idle();
        check("rl_sp", sp, 8'hFF);
        check("rl_wbv", 8'(wb_valid), 8'h00);
        check("rl_err", 8'(stk_err), 8'h00);
        tick();
        check("rl_wbv2", 8'(wb_valid), 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Memory-access pipeline stage that sits directly upstream of the 256x8 data memory (DataMEM).
- Converts EX/MEM operations (LOAD, STORE, PUSH, POP, CALL, RET) into the DataMEM WE/RE/A/WD controls.
- Owns the stack pointer and the MEM/WB pipeline register.
- Merges the data memory's registered read data into the write-back result and issues the RET program-counter redirect.

Parameters:
- STACK_TOP, 8'hFF, SP reset value and highest stack address; a POP at this SP is an underflow.
- STACK_BOTTOM, 8'hC0, lowest legal PUSH address; a PUSH when SP < STACK_BOTTOM is an overflow.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- stall  in  1  hold the stage: no memory access, SP and MEM/WB register frozen.
- flush  in  1  kill the current EX/MEM operation (no side effects).
- ex_valid  in  1  EX/MEM holds a valid instruction.
- ex_op  in  3  operation code: NOP, ALU, LOAD, STORE, PUSH, POP, CALL, RET.
- ex_addr  in  8  effective address for LOAD/STORE.
- ex_wdata  in  8  store or push data; for CALL, the return PC.
- ex_alu  in  8  ALU result, passed through for ALU ops.
- ex_rd  in  2  destination register index.
- ex_reg_we  in  1  register write request.
- mem_we  out  1  DataMEM WE.
- mem_re  out  1  DataMEM RE.
- mem_a  out  8  DataMEM address.
- mem_wd  out  8  DataMEM write data.
- mem_rd  in  8  DataMEM RD (registered; valid the cycle after RE).
- wb_valid  out  1  WB stage holds a valid instruction.
- wb_we  out  1  register-file write enable.
- wb_rd  out  2  register-file write index.
- wb_data  out  8  write-back data.
- ret_valid  out  1  one-cycle redirect strobe for RET.
- ret_pc  out  8  RET target.
- sp  out  8  current stack pointer.
- stk_err  out  1  sticky stack overflow/underflow flag.

Behaviour:
- Reset (rst_n low at the rising edge):
  - sp <= STACK_TOP; stk_err <= 0.
  - wb_valid, wb_we, wb_rd and the captured ALU value go to 0; ret_valid <= 0.
  - While rst_n is low, mem_we and mem_re are forced to 0 combinationally.
- Access qualifier: act = ex_valid & !stall & !flush & rst_n. When act is 0: mem_we = 0, mem_re = 0, mem_a = 0, mem_wd = 0.
- Memory drive, combinational, when act is 1:
  - LOAD: re=1, a=ex_addr.
  - STORE: we=1, a=ex_addr, wd=ex_wdata.
  - PUSH/CALL: we=1, a=sp, wd=ex_wdata.
  - POP/RET: re=1, a=sp+1.
  - NOP/ALU: no access.
- Stack model: full-descending.
  - PUSH/CALL: sp <= sp-1.
  - POP/RET: sp <= sp+1.
  - 8-bit arithmetic; wrap cannot occur because of the limit checks below.
- Overflow: PUSH/CALL with sp < STACK_BOTTOM.
  - we suppressed; sp unchanged; stk_err <= 1.
  - Instruction still retires; a CALL still redirects normally upstream.
- Underflow: POP/RET with sp == STACK_TOP.
  - re suppressed; sp unchanged; stk_err <= 1.
  - POP writes back 8'h00; RET raises no ret_valid.
- stk_err clears only on reset.
- MEM/WB register update:
  - stall: register holds all fields, and ret_valid <= 0.
  - Otherwise it captures: valid = ex_valid & !flush; we = ex_reg_we & valid; rd; a load flag (LOAD or a non-faulting POP); the ALU value; a zero flag for an underflowing POP.
- wb_data (combinational): mem_rd when the load flag is set, 8'h00 for an underflowing POP, otherwise the captured ALU value.
- Load latency: one cycle; LOAD data appears on wb_data in the cycle after the address is issued.
- While stalled with the load flag set, mem_rd stays stable because RE is 0, so wb_data holds.
- RET: ret_valid = 1 and ret_pc = mem_rd for exactly the one cycle after a non-faulting RET. RET writes no register.
- Flush: overrides the op in the same cycle. No memory access, SP unchanged, the bubble enters MEM/WB.
- Precedence: stall and flush together → flush takes precedence for memory/SP side effects; the MEM/WB register holds per the stall rule.
- Reset mid-operation: any in-flight load result is discarded and wb_valid is 0 on the first cycle after reset.

Decomposition:
- Shared package mem_pkg:
  - op-code constants OP_NOP=0, OP_ALU=1, OP_LOAD=2, OP_STORE=3, OP_PUSH=4, OP_POP=5, OP_CALL=6, OP_RET=7.
  - STACK_TOP and STACK_BOTTOM defaults.
- One sub-module, stack_ptr_unit:
  - holds sp and stk_err.
  - takes push/pop/enable.
  - returns the push address, pop address and fault flags.

Test Plan:
- Reset then STORE addr 8'h10 data 8'hA5, then LOAD 8'h10 with rd=2 → mem_we=1, a=8'h10 in the STORE cycle; the next cycle after the LOAD gives wb_we=1, wb_rd=2, wb_data=8'hA5.
- PUSH 8'h11, PUSH 8'h22, POP, POP → writes to FF then FE; sp goes FF→FE→FD→FE→FF; write-back data 8'h22 then 8'h11.
- CALL with ex_wdata=8'h40, then RET → mem[FF]=8'h40; ret_valid pulses one cycle with ret_pc=8'h40; sp returns to FF.
- POP at reset SP → mem_re=0; wb_data=8'h00; stk_err=1.
  - Then 64 PUSHes (FF down to C0), then a 65th PUSH → the 65th has mem_we=0, sp stays 8'hBF, stk_err stays 1.
- STORE with flush=1 → mem_we=0; next cycle wb_valid=0.
  - LOAD followed by stall=1 for 3 cycles → wb_data is held at the loaded value and sp is unchanged.
- Assert rst_n=0 during a LOAD → mem_re=0 in that cycle; after release sp=8'hFF, wb_valid=0, stk_err=0.
